// File: rtl/icache_assoc.sv
// Set-associative instruction cache with block fill, round-robin replacement and perf counters.
// Latency: hits answer combinationally; a miss spends one lookup cycle, then WORDS plus iwait-high cycles in FILL.
// Backpressure: memory stalls through iwait; dbusy or halt suppress lookups, and halt also drops any fill.
module icache_assoc #(
    parameter int WAYS  = 2,
    parameter int SETS  = 8,
    parameter int WORDS = 2,
    parameter int CNTW  = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            imemREN,
    input  logic [31:0]     imemaddr,
    input  logic            halt,
    input  logic            dbusy,
    output logic            ihit,
    output logic [31:0]     imemload,
    output logic            iREN,
    output logic [31:0]     iaddr,
    input  logic            iwait,
    input  logic [31:0]     iload,
    output logic [CNTW-1:0] hitcnt,
    output logic [CNTW-1:0] misscnt
);
    localparam int OB  = $clog2(WORDS);
    localparam int IB  = $clog2(SETS);
    localparam int TW  = 30 - OB - IB;
    localparam int OBW = (OB > 0) ? OB : 1;
    localparam int PW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [OBW-1:0]    wc_q;
    logic [TW-1:0]     fill_tag_q;
    logic [IB-1:0]     fill_idx_q;
    logic              valid_q  [WAYS][SETS];
    logic [TW-1:0]     tag_q    [WAYS][SETS];
    logic [31:0]       data_q   [WAYS][SETS][WORDS];
    logic [PW-1:0]     ptr_q    [SETS];
    logic [31:0]       linebuf_q [WORDS];
    logic [CNTW-1:0]   hitcnt_q, misscnt_q;

    logic [29:0]       waddr;
    logic [TW-1:0]     req_tag;
    logic [IB-1:0]     req_idx;
    logic [OBW-1:0]    req_off;
    logic              lookup, hit_any, miss_start, accept, fill_done, all_valid;
    logic [31:0]       hit_word, fill_base;
    logic [PW-1:0]     victim;
    logic              unused_ok;

    assign waddr      = imemaddr[31:2];
    assign req_tag    = waddr[29 -: TW];
    assign req_idx    = waddr[OB +: IB];
    assign unused_ok  = ^imemaddr[1:0];
    assign fill_base  = {fill_tag_q, fill_idx_q, {(OB + 2){1'b0}}};

    // Word offset only exists for multi-word blocks.
    always_comb begin
        req_off = '0;
        if (WORDS > 1) req_off = waddr[OBW-1:0];
    end

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit_any  = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
                hit_any  = 1'b1;
                hit_word = data_q[w][req_idx][req_off];
            end
        end
    end

    assign lookup     = imemREN && !dbusy && !halt && (state_q == IDLE);
    assign ihit       = lookup && hit_any;
    assign imemload   = ihit ? hit_word : 32'd0;
    assign miss_start = lookup && !hit_any;
    assign accept     = (state_q == FILL) && !iwait && !halt;
    assign hitcnt     = hitcnt_q;
    assign misscnt    = misscnt_q;

    // Victim: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim    = ptr_q[fill_idx_q];
        all_valid = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][fill_idx_q]) begin
                victim    = PW'(w);
                all_valid = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and memory-side outputs; halt overrides everything.
    always_comb begin
        state_d   = state_q;
        iREN      = 1'b0;
        iaddr     = 32'd0;
        fill_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_start) state_d = FILL;
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = fill_base | (32'(wc_q) << 2);
                if (!iwait && wc_q == OBW'(WORDS - 1)) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (halt) begin
            state_d   = IDLE;
            iREN      = 1'b0;
            iaddr     = 32'd0;
            fill_done = 1'b0;
        end
    end

    // Control state: fill address, word counter, valid bits, pointers, counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wc_q       <= '0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            hitcnt_q   <= '0;
            misscnt_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) valid_q[w][s] <= 1'b0;
            end
        end else begin
            if (ihit) hitcnt_q <= hitcnt_q + CNTW'(1);
            if (miss_start) begin
                misscnt_q  <= misscnt_q + CNTW'(1);
                fill_tag_q <= req_tag;
                fill_idx_q <= req_idx;
                wc_q       <= '0;
            end
            if (accept && WORDS > 1) wc_q <= wc_q + OBW'(1);
            if (halt) begin
                for (int s = 0; s < SETS; s++) begin
                    ptr_q[s] <= '0;
                    for (int w = 0; w < WAYS; w++) valid_q[w][s] <= 1'b0;
                end
            end else if (fill_done) begin
                valid_q[victim][fill_idx_q] <= 1'b1;
                if (all_valid && WAYS > 1) ptr_q[fill_idx_q] <= ptr_q[fill_idx_q] + PW'(1);
            end
        end
    end

    // Line buffer capture and array write; contents need no reset since valid gates them.
    always_ff @(posedge CLK) begin
        if (accept) linebuf_q[wc_q] <= iload;
        if (fill_done) begin
            tag_q[victim][fill_idx_q] <= fill_tag_q;
            for (int k = 0; k < WORDS; k++) begin
                data_q[victim][fill_idx_q][k] <= (k == WORDS - 1) ? iload : linebuf_q[k];
            end
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
module tb_icache_assoc;
    logic        CLK, RST, imemREN, halt, dbusy, iwait;
    logic [31:0] imemaddr, iload, imemload, iaddr;
    logic        ihit, iREN;
    logic [31:0] hitcnt, misscnt;

    icache_assoc #(.WAYS(2), .SETS(8), .WORDS(2), .CNTW(32)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .halt(halt), .dbusy(dbusy), .ihit(ihit), .imemload(imemload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .hitcnt(hitcnt), .misscnt(misscnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        hlt;
        logic        db;
        logic        iw;
        logic [31:0] ld;
        logic        e_ihit;
        logic [31:0] e_load;
        logic        e_iren;
        logic        chk_addr;
        logic [31:0] e_iaddr;
        logic [31:0] e_hit;
        logic [31:0] e_miss;
    } vec_t;

    vec_t vq[$];
    int   passed = 0;
    int   total  = 0;

    function automatic void v(logic ren, logic [31:0] addr, logic hlt, logic db, logic iw,
                              logic [31:0] ld, logic eh, logic [31:0] el, logic er,
                              logic ca, logic [31:0] ea, logic [31:0] ehc, logic [31:0] emc);
        vec_t t;
        t.ren = ren; t.addr = addr; t.hlt = hlt; t.db = db; t.iw = iw; t.ld = ld;
        t.e_ihit = eh; t.e_load = el; t.e_iren = er; t.chk_addr = ca; t.e_iaddr = ea;
        t.e_hit = ehc; t.e_miss = emc;
        vq.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic drive(input logic ren, input logic [31:0] addr, input logic hlt,
                         input logic db, input logic iw, input logic [31:0] ld);
        imemREN = ren; imemaddr = addr; halt = hlt; dbusy = db; iwait = iw; iload = ld;
    endtask

    initial begin
        RST = 1'b1;
        drive(0, 0, 0, 0, 1, 0);

        //   ren addr      h db iw iload         ihit load          iren ca iaddr    hit miss
        // cold miss of 0x40, then both words hit
        v(1, 'h40,  0, 0, 1, 0,            0, 0,            0, 1, 0,      0, 0);
        v(1, 'h40,  0, 0, 0, 'hAAAA0001,   0, 0,            1, 1, 'h40,   0, 1);
        v(1, 'h40,  0, 0, 0, 'hAAAA0002,   0, 0,            1, 1, 'h44,   0, 1);
        v(1, 'h40,  0, 0, 1, 0,            1, 'hAAAA0001,   0, 1, 0,      0, 1);
        v(1, 'h44,  0, 0, 1, 0,            1, 'hAAAA0002,   0, 1, 0,      1, 1);
        v(0, 0,     0, 0, 1, 0,            0, 0,            0, 1, 0,      2, 1);
        // fill 0x80 into way 1 of set 0, with one stall cycle
        v(1, 'h80,  0, 0, 1, 0,            0, 0,            0, 1, 0,      2, 1);
        v(1, 'h80,  0, 0, 1, 0,            0, 0,            1, 1, 'h80,   2, 2);
        v(1, 'h80,  0, 0, 0, 'hBBBB0001,   0, 0,            1, 1, 'h80,   2, 2);
        v(1, 'h80,  0, 0, 0, 'hBBBB0002,   0, 0,            1, 1, 'h84,   2, 2);
        v(1, 'h40,  0, 0, 1, 0,            1, 'hAAAA0001,   0, 1, 0,      2, 2);
        v(1, 'h84,  0, 0, 1, 0,            1, 'hBBBB0002,   0, 1, 0,      3, 2);
        // 0xC0 evicts way 0 (0x40), pointer -> 1
        v(1, 'hC0,  0, 0, 1, 0,            0, 0,            0, 1, 0,      4, 2);
        v(1, 'hC0,  0, 0, 0, 'hCCCC0001,   0, 0,            1, 1, 'hC0,   4, 3);
        v(1, 'hC0,  0, 0, 0, 'hCCCC0002,   0, 0,            1, 1, 'hC4,   4, 3);
        v(1, 'h80,  0, 0, 1, 0,            1, 'hBBBB0001,   0, 1, 0,      4, 3);
        v(1, 'hC4,  0, 0, 1, 0,            1, 'hCCCC0002,   0, 1, 0,      5, 3);
        // 0x40 now misses and replaces way 1 (0x80)
        v(1, 'h40,  0, 0, 1, 0,            0, 0,            0, 1, 0,      6, 3);
        v(1, 'h40,  0, 0, 0, 'hAAAA0001,   0, 0,            1, 1, 'h40,   6, 4);
        v(1, 'h40,  0, 0, 0, 'hAAAA0002,   0, 0,            1, 1, 'h44,   6, 4);
        // dbusy blocks lookups, hit returns the same cycle it drops
        v(1, 'h40,  0, 1, 1, 0,            0, 0,            0, 1, 0,      6, 4);
        v(1, 'h40,  0, 1, 1, 0,            0, 0,            0, 1, 0,      6, 4);
        v(1, 'h40,  0, 1, 1, 0,            0, 0,            0, 1, 0,      6, 4);
        v(1, 'h40,  0, 0, 1, 0,            1, 'hAAAA0001,   0, 1, 0,      6, 4);
        // halt lands on the final word of a 0x100 fill: nothing written, all invalidated
        v(1, 'h100, 0, 0, 1, 0,            0, 0,            0, 1, 0,      7, 4);
        v(1, 'h100, 0, 0, 0, 'hDDDD0001,   0, 0,            1, 1, 'h100,  7, 5);
        v(1, 'h100, 1, 0, 0, 'hDDDD0002,   0, 0,            0, 0, 0,      7, 5);
        v(0, 0,     0, 0, 1, 0,            0, 0,            0, 1, 0,      7, 5);
        v(1, 'h40,  0, 0, 1, 0,            0, 0,            0, 1, 0,      7, 5);
        // redirect to 0x200 mid-fill: 0x40 fill still completes, then 0x200 misses
        v(1, 'h200, 0, 0, 0, 'hAAAA0001,   0, 0,            1, 1, 'h40,   7, 6);
        v(1, 'h200, 0, 0, 0, 'hAAAA0002,   0, 0,            1, 1, 'h44,   7, 6);
        v(1, 'h200, 0, 0, 1, 0,            0, 0,            0, 1, 0,      7, 6);
        v(1, 'h200, 0, 0, 0, 'hEEEE0001,   0, 0,            1, 1, 'h200,  7, 7);
        v(1, 'h200, 0, 0, 0, 'hEEEE0002,   0, 0,            1, 1, 'h204,  7, 7);
        v(1, 'h204, 0, 0, 1, 0,            1, 'hEEEE0002,   0, 1, 0,      7, 7);
        v(1, 'h40,  0, 0, 1, 0,            1, 'hAAAA0001,   0, 1, 0,      8, 7);
        // halted line 0x100 was never written
        v(1, 'h100, 0, 0, 1, 0,            0, 0,            0, 1, 0,      9, 7);

        // reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst ihit", 32'(ihit), 0);
        chk("rst imemload", imemload, 0);
        chk("rst iREN", 32'(iREN), 0);
        chk("rst iaddr", iaddr, 0);
        chk("rst hitcnt", hitcnt, 0);
        chk("rst misscnt", misscnt, 0);
        RST = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge CLK);
            drive(vq[i].ren, vq[i].addr, vq[i].hlt, vq[i].db, vq[i].iw, vq[i].ld);
            #1;
            chk($sformatf("v%0d ihit", i), 32'(ihit), 32'(vq[i].e_ihit));
            chk($sformatf("v%0d imemload", i), imemload, vq[i].e_load);
            chk($sformatf("v%0d iREN", i), 32'(iREN), 32'(vq[i].e_iren));
            if (vq[i].chk_addr) chk($sformatf("v%0d iaddr", i), iaddr, vq[i].e_iaddr);
            chk($sformatf("v%0d hitcnt", i), hitcnt, vq[i].e_hit);
            chk($sformatf("v%0d misscnt", i), misscnt, vq[i].e_miss);
        end

        // async reset in the middle of the stalled 0x100 fill
        @(negedge CLK);
        drive(1, 'h100, 0, 0, 1, 0);
        #1;
        chk("fill iREN", 32'(iREN), 1);
        chk("fill iaddr", iaddr, 'h100);
        chk("fill misscnt", misscnt, 8);
        #1 RST = 1'b1;
        #1;
        chk("arst iREN", 32'(iREN), 0);
        chk("arst ihit", 32'(ihit), 0);
        chk("arst hitcnt", hitcnt, 0);
        chk("arst misscnt", misscnt, 0);
        @(negedge CLK);
        RST = 1'b0;
        drive(1, 'h40, 0, 0, 1, 0);
        #1;
        chk("post-rst 0x40 ihit", 32'(ihit), 0);
        @(negedge CLK);
        #1;
        chk("post-rst iREN", 32'(iREN), 1);
        chk("post-rst iaddr", iaddr, 'h40);
        chk("post-rst misscnt", misscnt, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
